vga_sprite: RTL

Pixel-colour stage fed directly by the VGA timing generator. It consumes the generator's one-cycle line and frame strobes and rebuilds its own column and row position from them. Each frame it draws a white border around the 640x480 active area and a solid bouncing square whose colour changes on every wall hit. Outputs are 4-bit-per-channel RGB plus re-timed sync strobes for the DAC/pin stage.

---
 rtl/vga_sprite.sv | 82 ++++++++
 1 files changed

// File: rtl/vga_sprite.sv
// vga_sprite: rebuilds pixel position from line/frame strobes and paints a border plus a bouncing square.
module vga_sprite #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BOX      = 32,
   parameter int H_STEP   = 2,
   parameter int V_STEP   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       freeze,
   output logic [3:0] r_out,
   output logic [3:0] g_out,
   output logic [3:0] b_out,
   output logic       hs_out,
   output logic       vs_out
);
   localparam logic [10:0] HA = 11'(H_ACTIVE);
   localparam logic [10:0] VA = 11'(V_ACTIVE);
   localparam logic [10:0] BX = 11'(BOX);
   localparam logic [10:0] HS = 11'(H_STEP);
   localparam logic [10:0] VS = 11'(V_STEP);
   localparam logic [11:0] PAL [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                       12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
   logic [9:0] col, bx, nbx;
   logic [8:0] row, by, nby;
   logic dir_x, dir_y;
   logic [2:0] cidx, cidx_n;
   logic [10:0] col_w, row_w, bx_w, by_w;
   logic hit_r, hit_l, hit_d, hit_u, bnc_x, bnc_y;
   logic blank, in_spr, border;
   logic [11:0] rgb;
   // 11-bit views keep edge sums from wrapping
   always_comb begin
      col_w  = {1'b0, col};
      row_w  = {2'b0, row};
      bx_w   = {1'b0, bx};
      by_w   = {2'b0, by};
      hit_r  = !dir_x && (bx_w + BX + HS > HA);
      hit_l  = dir_x && (bx_w < HS);
      hit_d  = !dir_y && (by_w + BX + VS > VA);
      hit_u  = dir_y && (by_w < VS);
      bnc_x  = hit_r | hit_l;
      bnc_y  = hit_d | hit_u;
      nbx    = hit_r ? 10'(H_ACTIVE - BOX) : hit_l ? '0 : dir_x ? bx - 10'(H_STEP) : bx + 10'(H_STEP);
      nby    = hit_d ? 9'(V_ACTIVE - BOX) : hit_u ? '0 : dir_y ? by - 9'(V_STEP) : by + 9'(V_STEP);
      cidx_n = cidx + 3'(bnc_x) + 3'(bnc_y);
      blank  = (col_w >= HA) || (row_w >= VA);
      in_spr = (col_w >= bx_w) && (col_w < bx_w + BX) && (row_w >= by_w) && (row_w < by_w + BX);
      border = (col == '0) || (col_w == HA - 11'd1) || (row == '0) || (row_w == VA - 11'd1);
      rgb    = blank ? 12'h000 : in_spr ? PAL[cidx] : border ? 12'hFFF : 12'h000;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= '1;
         row    <= '1;
         bx     <= '0;
         by     <= '0;
         dir_x  <= 1'b0;
         dir_y  <= 1'b0;
         cidx   <= '0;
         {r_out, g_out, b_out} <= '0;
         hs_out <= 1'b0;
         vs_out <= 1'b0;
      end else begin
         col <= hs_in ? '0 : (&col) ? col : col + 10'd1;
         row <= vs_in ? '0 : (hs_in && !(&row)) ? row + 9'd1 : row;
         if (vs_in && !freeze) begin
            bx    <= nbx;
            by    <= nby;
            dir_x <= dir_x ^ bnc_x;
            dir_y <= dir_y ^ bnc_y;
            cidx  <= cidx_n;
         end
         {r_out, g_out, b_out} <= rgb;
         hs_out <= hs_in;
         vs_out <= vs_in;
      end
   end
endmodule
